// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM states,
// default field widths and the end/rest marker values of a note entry.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_ADVANCE
    } state_t;

    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_STEP_BITS = 6;
    localparam int DEF_DUR_BITS  = 16;

    // A note entry is packed as {step, dur}.
    localparam int END_DUR   = 0;
    localparam int REST_STEP = 0;

    function automatic int entry_bits(input int step_bits, input int dur_bits);
        return step_bits + dur_bits;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider: tick is high on the terminal count of a
// 0..TICK_DIV-1 counter; clr restarts the count from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Plays a host-written table of {step, duration} notes onto the sine
// generator's step input, muting during rests and inter-note gaps.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int STEP_BITS = DEF_STEP_BITS,
    parameter int DUR_BITS  = DEF_DUR_BITS,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [STEP_BITS-1:0] wr_step,
    input  logic [DUR_BITS-1:0]  wr_dur,
    output logic [STEP_BITS-1:0] step,
    output logic                 mute,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] note_idx
);

    localparam int ENTRY_BITS = entry_bits(STEP_BITS, DUR_BITS);
    localparam int DEPTH      = 1 << ADDR_BITS;
    localparam int GAP_W      = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    localparam state_t AFTER_PLAY = (GAP_TICKS == 0) ? S_ADVANCE : S_GAP;

    logic [ENTRY_BITS-1:0] r_table [DEPTH];

    state_t                r_state;
    logic [STEP_BITS-1:0]  r_step;
    logic                  r_mute;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_BITS-1:0]  r_note_idx;
    logic [DUR_BITS-1:0]   r_dur_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;

    logic [ENTRY_BITS-1:0] w_entry;
    logic [STEP_BITS-1:0]  w_fetch_step;
    logic [DUR_BITS-1:0]   w_fetch_dur;
    logic                  w_tick;
    logic                  w_presc_clr;

    // Table survives rst so a replay after reset uses the same notes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= {wr_step, wr_dur};
        end
    end

    assign w_entry      = r_table[r_note_idx];
    assign w_fetch_step = w_entry[ENTRY_BITS-1 -: STEP_BITS];
    assign w_fetch_dur  = w_entry[DUR_BITS-1:0];

    // Prescaler only runs while timing a note or gap, so each note starts on a tick boundary.
    assign w_presc_clr = (r_state != S_PLAY) && (r_state != S_GAP);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_mute     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_note_idx <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                r_mute  <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_note_idx <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (w_fetch_dur != DUR_BITS'(END_DUR)) begin
                            r_step    <= w_fetch_step;
                            r_mute    <= (w_fetch_step == STEP_BITS'(REST_STEP));
                            r_dur_cnt <= w_fetch_dur;
                            r_state   <= S_PLAY;
                        end else if (loop && (r_note_idx != '0)) begin
                            r_note_idx <= '0;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_mute  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_PLAY: begin
                        if (w_tick) begin
                            r_dur_cnt <= r_dur_cnt - DUR_BITS'(1);
                            if (r_dur_cnt == DUR_BITS'(1)) begin
                                r_mute    <= 1'b1;
                                r_gap_cnt <= '0;
                                r_state   <= AFTER_PLAY;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_tick) begin
                            if (r_gap_cnt == GAP_LAST) begin
                                r_state <= S_ADVANCE;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                            end
                        end
                    end
                    S_ADVANCE: begin
                        // Stepping past the last entry ends the sequence like a dur=0 marker.
                        if (&r_note_idx) begin
                            if (loop) begin
                                r_note_idx <= '0;
                                r_state    <= S_FETCH;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_note_idx <= r_note_idx + ADDR_BITS'(1);
                            r_state    <= S_FETCH;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign step     = r_step;
    assign mute     = r_mute;
    assign busy     = r_busy;
    assign done     = r_done;
    assign note_idx = r_note_idx;

endmodule
